// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
//   Owns the single asynchronous SRAM port. It is shared between two masters:
//   - an SPI slave. Its memory strobes come from the sck domain.
//   - an EPROM-emulation socket. Target reads come from the host bus.
//   The SPI strobes and the socket controls are synchronised into clk and
//   turned into one-cycle request pulses. The block then arbitrates between
//   them, with the target always winning, and runs timed SRAM cycles.
//
// Parameters
//   ADDR_WIDTH  SRAM / EPROM address width
//   DATA_WIDTH  data width
//   ACC_CYCLES  clk cycles that sram_oe_n / sram_we_n stay active (>= 1)
//
// Ports
//   clk, rst                      system clock, synchronous active-high reset
//   spi_addr, spi_wdata           SPI address / write data (sck domain)
//   spi_oe_n, spi_we_n            SPI read / write strobes, active low, async
//   spi_rdata                     data returned to the SPI slave
//   tgt_addr, tgt_ce_n, tgt_oe_n  EPROM socket address and controls, async
//   tgt_rdata, tgt_drive          socket read data and socket driver enable
//   sram_addr, sram_dq_o/_i/_oe   SRAM address, data out / in, DQ drive enable
//   sram_ce_n/oe_n/we_n           SRAM controls, active low
//   stat_defer                    (SRAM_ARB_STATS_EN only) SPI grants that
//                                 waited behind a target grant, saturating
//
// Configuration macro: SRAM_ARB_STATS_EN adds the stat_defer counter/port.
// The SPI clock must satisfy f_sck <= f_clk/6.
// -----------------------------------------------------------------------------
module sram_arbiter #(
  parameter int ADDR_WIDTH = 18,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] spi_addr,
  input  logic [DATA_WIDTH-1:0] spi_wdata,
  input  logic                  spi_oe_n,
  input  logic                  spi_we_n,
  output logic [DATA_WIDTH-1:0] spi_rdata,
  input  logic [ADDR_WIDTH-1:0] tgt_addr,
  input  logic                  tgt_ce_n,
  input  logic                  tgt_oe_n,
  output logic [DATA_WIDTH-1:0] tgt_rdata,
  output logic                  tgt_drive,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_dq_o,
  input  logic [DATA_WIDTH-1:0] sram_dq_i,
  output logic                  sram_dq_oe,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n
`ifdef SRAM_ARB_STATS_EN
  ,
  output logic [15:0]           stat_defer
`endif
);

  localparam int CNT_W = $clog2(ACC_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACC_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    TGT_RD,
    SPI_RD,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD
  } state_t;

  state_t state;
  logic [CNT_W-1:0] cnt;

  // ---------------------------------------------------------------------------
  // Synchronisers and edge detection
  // ---------------------------------------------------------------------------
  logic [1:0]            spi_oe_sync, spi_we_sync, tgt_ce_sync, tgt_oe_sync;
  logic [ADDR_WIDTH-1:0] spi_addr_m, spi_addr_s, tgt_addr_m, tgt_addr_s;
  logic [DATA_WIDTH-1:0] spi_wdata_m, spi_wdata_s;
  logic                  spi_oe_prev, spi_we_prev, tgt_act_prev;
  logic [ADDR_WIDTH-1:0] tgt_addr_prev;

  // NOTE: every flop uses non-blocking assignments, so all registers update
  // together from the values they had before the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      spi_oe_sync   <= '1;
      spi_we_sync   <= '1;
      tgt_ce_sync   <= '1;
      tgt_oe_sync   <= '1;
      spi_addr_m    <= '0;
      spi_addr_s    <= '0;
      spi_wdata_m   <= '0;
      spi_wdata_s   <= '0;
      tgt_addr_m    <= '0;
      tgt_addr_s    <= '0;
      spi_oe_prev   <= 1'b1;
      spi_we_prev   <= 1'b1;
      tgt_act_prev  <= 1'b0;
      tgt_addr_prev <= '0;
    end else begin
      spi_oe_sync   <= {spi_oe_sync[0], spi_oe_n};
      spi_we_sync   <= {spi_we_sync[0], spi_we_n};
      tgt_ce_sync   <= {tgt_ce_sync[0], tgt_ce_n};
      tgt_oe_sync   <= {tgt_oe_sync[0], tgt_oe_n};
      spi_addr_m    <= spi_addr;
      spi_addr_s    <= spi_addr_m;
      spi_wdata_m   <= spi_wdata;
      spi_wdata_s   <= spi_wdata_m;
      tgt_addr_m    <= tgt_addr;
      tgt_addr_s    <= tgt_addr_m;
      spi_oe_prev   <= spi_oe_sync[1];
      spi_we_prev   <= spi_we_sync[1];
      tgt_act_prev  <= tgt_drive;
      tgt_addr_prev <= tgt_addr_s;
    end
  end

  logic spi_rd_req, spi_wr_req, tgt_req;

  assign spi_rd_req = spi_oe_prev & ~spi_oe_sync[1];
  assign spi_wr_req = spi_we_prev & ~spi_we_sync[1];
  assign tgt_drive  = ~tgt_ce_sync[1] & ~tgt_oe_sync[1];
  // A new socket cycle is either the select becoming active, or an address
  // change while it stays active (the host walks addresses with ce/oe held low).
  assign tgt_req    = tgt_drive & (~tgt_act_prev | (tgt_addr_s != tgt_addr_prev));

  // ---------------------------------------------------------------------------
  // Pending requests and arbitration
  // ---------------------------------------------------------------------------
  logic                  tgt_pend, spi_wr_pend, spi_rd_pend;
  logic [ADDR_WIDTH-1:0] tgt_addr_cap, spi_wr_addr, spi_rd_addr;
  logic [DATA_WIDTH-1:0] spi_wr_data;
  logic                  grant_tgt, grant_wr, grant_rd;

  assign grant_tgt = (state == IDLE) & tgt_pend;
  assign grant_wr  = (state == IDLE) & ~tgt_pend & spi_wr_pend;
  assign grant_rd  = (state == IDLE) & ~tgt_pend & ~spi_wr_pend & spi_rd_pend;

  // ---------------------------------------------------------------------------
  // Access FSM with registered SRAM controls
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      tgt_pend     <= 1'b0;
      spi_wr_pend  <= 1'b0;
      spi_rd_pend  <= 1'b0;
      tgt_addr_cap <= '0;
      spi_wr_addr  <= '0;
      spi_rd_addr  <= '0;
      spi_wr_data  <= '0;
      sram_addr    <= '0;
      sram_dq_o    <= '0;
      sram_dq_oe   <= 1'b0;
      sram_ce_n    <= 1'b1;
      sram_oe_n    <= 1'b1;
      sram_we_n    <= 1'b1;
      spi_rdata    <= '0;
      tgt_rdata    <= '0;
    end else begin
      // A request pulse takes priority over its own grant. A request that
      // arrives in the grant cycle is new, so it must stay pending.
      if (tgt_req) begin
        tgt_pend     <= 1'b1;
        tgt_addr_cap <= tgt_addr_s;
      end else if (grant_tgt) begin
        tgt_pend <= 1'b0;
      end

      if (spi_wr_req) begin
        spi_wr_pend <= 1'b1;
        spi_wr_addr <= spi_addr_s;
        spi_wr_data <= spi_wdata_s;
      end else if (grant_wr) begin
        spi_wr_pend <= 1'b0;
      end

      if (spi_rd_req) begin
        spi_rd_pend <= 1'b1;
        spi_rd_addr <= spi_addr_s;
      end else if (grant_rd) begin
        spi_rd_pend <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (grant_tgt) begin
            state     <= TGT_RD;
            sram_addr <= tgt_addr_cap;
            sram_ce_n <= 1'b0;
            sram_oe_n <= 1'b0;
            cnt       <= CNT_LOAD;
          end else if (grant_wr) begin
            // DQ is driven a cycle before we_n falls and released a cycle
            // after it rises. sram_oe_n stays high for the whole write.
            state      <= WR_SETUP;
            sram_addr  <= spi_wr_addr;
            sram_dq_o  <= spi_wr_data;
            sram_dq_oe <= 1'b1;
            sram_ce_n  <= 1'b0;
          end else if (grant_rd) begin
            state     <= SPI_RD;
            sram_addr <= spi_rd_addr;
            sram_ce_n <= 1'b0;
            sram_oe_n <= 1'b0;
            cnt       <= CNT_LOAD;
          end
        end

        TGT_RD, SPI_RD: begin
          if (cnt == '0) begin
            if (state == TGT_RD) tgt_rdata <= sram_dq_i;
            else                 spi_rdata <= sram_dq_i;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            state     <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        WR_SETUP: begin
          state     <= WR_PULSE;
          sram_we_n <= 1'b0;
          cnt       <= CNT_LOAD;
        end

        WR_PULSE: begin
          if (cnt == '0) begin
            sram_we_n <= 1'b1;
            state     <= WR_HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        WR_HOLD: begin
          sram_dq_oe <= 1'b0;
          sram_ce_n  <= 1'b1;
          state      <= IDLE;
        end

        default: begin
          sram_dq_oe <= 1'b0;
          sram_ce_n  <= 1'b1;
          sram_oe_n  <= 1'b1;
          sram_we_n  <= 1'b1;
          state      <= IDLE;
        end
      endcase
    end
  end

`ifdef SRAM_ARB_STATS_EN
  // ---------------------------------------------------------------------------
  // Deferral statistics. A pending SPI request is marked when a target grant
  // passes it. It is counted once, when it is finally granted.
  // ---------------------------------------------------------------------------
  logic rd_deferred, wr_deferred;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_deferred <= 1'b0;
      wr_deferred <= 1'b0;
      stat_defer  <= '0;
    end else begin
      if (grant_rd)                     rd_deferred <= 1'b0;
      else if (spi_rd_pend & grant_tgt) rd_deferred <= 1'b1;

      if (grant_wr)                     wr_deferred <= 1'b0;
      else if (spi_wr_pend & grant_tgt) wr_deferred <= 1'b1;

      if (((grant_rd & rd_deferred) | (grant_wr & wr_deferred)) &&
          (stat_defer != 16'hFFFF))
        stat_defer <= stat_defer + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_arbiter
//   Self-checking bench for sram_arbiter.
//   - A behavioural SRAM model answers the DUT's SRAM port.
//   - A separate reference memory holds the bytes each address should contain.
//   - Monitors log every SRAM read and write cycle: address, data and pulse
//     length. They also count protocol conflicts.
//   - Stimulus is directed scenarios plus a randomised mix of SPI writes, SPI
//     reads and target reads.
// -----------------------------------------------------------------------------
module tb_sram_arbiter;

  localparam int AW  = 18;
  localparam int DW  = 8;
  localparam int ACC = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] spi_addr, tgt_addr, sram_addr;
  logic [DW-1:0] spi_wdata, spi_rdata, tgt_rdata, sram_dq_o, sram_dq_i;
  logic          spi_oe_n, spi_we_n, tgt_ce_n, tgt_oe_n, tgt_drive;
  logic          sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;
`ifdef SRAM_ARB_STATS_EN
  logic [15:0]   stat_defer;
`endif

  sram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ACC_CYCLES(ACC)) dut (
    .clk(clk), .rst(rst),
    .spi_addr(spi_addr), .spi_wdata(spi_wdata),
    .spi_oe_n(spi_oe_n), .spi_we_n(spi_we_n), .spi_rdata(spi_rdata),
    .tgt_addr(tgt_addr), .tgt_ce_n(tgt_ce_n), .tgt_oe_n(tgt_oe_n),
    .tgt_rdata(tgt_rdata), .tgt_drive(tgt_drive),
    .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i),
    .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
`ifdef SRAM_ARB_STATS_EN
    , .stat_defer(stat_defer)
`endif
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // ---------------------------------------------------------------------------
  // SRAM model, reference memory and access monitors
  // ---------------------------------------------------------------------------
  function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  logic [DW-1:0] mem     [logic [AW-1:0]];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [7:0]    len;
  } acc_t;

  acc_t rd_log[$], wr_log[$];
  acc_t rd_cur, wr_cur;
  logic [7:0] rd_len = 0, wr_len = 0;
  int conflicts = 0, glitches = 0;

  always @(negedge clk) begin
    if (!sram_ce_n && !sram_we_n) mem[sram_addr] = sram_dq_o;
    if (!sram_ce_n && !sram_oe_n)
      sram_dq_i = mem.exists(sram_addr) ? mem[sram_addr] : dflt(sram_addr);
    else
      sram_dq_i = '0;
    if ((sram_dq_oe && !sram_oe_n) || (!sram_oe_n && !sram_we_n)) conflicts++;

    if (!sram_oe_n) begin
      if (rd_len == 0) rd_cur.addr = sram_addr;
      else if (sram_addr !== rd_cur.addr) glitches++;
      rd_len++;
    end else if (rd_len != 0) begin
      rd_cur.len  = rd_len;
      rd_cur.data = '0;
      rd_log.push_back(rd_cur);
      rd_len = 0;
    end

    if (!sram_we_n) begin
      if (wr_len == 0) begin
        wr_cur.addr = sram_addr;
        wr_cur.data = sram_dq_o;
      end else if (sram_addr !== wr_cur.addr || sram_dq_o !== wr_cur.data || !sram_dq_oe) begin
        glitches++;
      end
      wr_len++;
    end else if (wr_len != 0) begin
      wr_cur.len = wr_len;
      wr_log.push_back(wr_cur);
      wr_len = 0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus tasks
  // ---------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n0;
    n0 = wr_log.size();
    spi_addr = a; spi_wdata = d;
    tick(1);
    spi_we_n = 1'b0;
    tick(6);
    spi_we_n = 1'b1;
    tick(8);
    ref_mem[a] = d;
    check("wr_count", wr_log.size(), n0 + 1);
    if (wr_log.size() > n0) begin
      check("wr_addr", wr_log[n0].addr, a);
      check("wr_data", wr_log[n0].data, d);
      check("wr_len",  wr_log[n0].len,  ACC);
    end
  endtask

  task automatic spi_read(input logic [AW-1:0] a, input string tag);
    int  lat;
    bit  seen, done;
    spi_addr = a;
    tick(1);
    spi_oe_n = 1'b0;
    lat = 0; seen = 0; done = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 6) spi_oe_n = 1'b1;
      if (!done) begin
        if (!sram_oe_n) seen = 1;
        else if (seen) begin done = 1; lat = i; end
      end
    end
    check({tag, "_lat_ok"}, (done && lat <= 8), 1);
    check({tag, "_data"}, spi_rdata, ref_rd(a));
  endtask

  task automatic tgt_read(input logic [AW-1:0] a);
    int n0;
    n0 = rd_log.size();
    tgt_addr = a; tgt_ce_n = 1'b0; tgt_oe_n = 1'b0;
    tick(10);
    check("tgt_drive_on", tgt_drive, 1);
    check("tgt_rdata", tgt_rdata, ref_rd(a));
    check("tgt_rd_count", rd_log.size(), n0 + 1);
    if (rd_log.size() > n0) check("tgt_rd_addr", rd_log[n0].addr, a);
    tgt_ce_n = 1'b1; tgt_oe_n = 1'b1;
    tick(4);
    check("tgt_drive_off", tgt_drive, 0);
  endtask

  // Target and SPI read strobes fall together: the target read must go first.
  task automatic concurrent_reads(input logic [AW-1:0] ta, input logic [AW-1:0] sa);
    int n0;
    n0 = rd_log.size();
    tgt_addr = ta; spi_addr = sa;
    tick(1);
    tgt_ce_n = 1'b0; tgt_oe_n = 1'b0; spi_oe_n = 1'b0;
    tick(6);
    spi_oe_n = 1'b1;
    tick(12);
    check("conc_rd_count", rd_log.size(), n0 + 2);
    if (rd_log.size() >= n0 + 2) begin
      check("conc_first_tgt", rd_log[n0].addr, ta);
      check("conc_second_spi", rd_log[n0 + 1].addr, sa);
    end
    check("conc_tgt_rdata", tgt_rdata, ref_rd(ta));
    check("conc_spi_rdata", spi_rdata, ref_rd(sa));
    tgt_ce_n = 1'b1; tgt_oe_n = 1'b1;
    tick(4);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int lat, n0;
    sram_dq_i = '0;
    rst = 1'b1;
    spi_addr = '0; spi_wdata = '0; spi_oe_n = 1'b1; spi_we_n = 1'b1;
    tgt_addr = '0; tgt_ce_n = 1'b1; tgt_oe_n = 1'b1;
    tick(2);
    check("rst_ce_n",  sram_ce_n,  1);
    check("rst_oe_n",  sram_oe_n,  1);
    check("rst_we_n",  sram_we_n,  1);
    check("rst_dq_oe", sram_dq_oe, 0);
    check("rst_addr",  sram_addr,  0);
    check("rst_dq_o",  sram_dq_o,  0);
    check("rst_spi_rdata", spi_rdata, 0);
    check("rst_tgt_rdata", tgt_rdata, 0);
    check("rst_tgt_drive", tgt_drive, 0);
`ifdef SRAM_ARB_STATS_EN
    check("rst_stat_defer", stat_defer, 0);
`endif
    rst = 1'b0;
    tick(2);

    // Directed write/read of a known location
    spi_write(18'h00123, 8'hA5);
    spi_read(18'h00123, "spi_rd_123");

    // Concurrent target read of 0x123 and SPI read of 0x000
    concurrent_reads(18'h00123, 18'h00000);

    // Target request while a write pulse is in progress
    fork
      spi_write(18'h00456, 8'h5A);
      begin
        for (int i = 0; i < 30 && sram_we_n; i++) @(negedge clk);
        check("midwr_saw_pulse", !sram_we_n, 1);
        tgt_addr = 18'h00123; tgt_ce_n = 1'b0; tgt_oe_n = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
          @(negedge clk);
          if (!sram_oe_n) begin lat = i; break; end
        end
        check("midwr_tgt_lat_ok", (lat != 0 && lat <= ACC + 3), 1);
        tick(6);
        check("midwr_tgt_rdata", tgt_rdata, 8'hA5);
        tgt_ce_n = 1'b1; tgt_oe_n = 1'b1;
        tick(4);
      end
    join
    spi_read(18'h00456, "spi_rd_456");

    // Randomised mix over a small address pool so reads hit written bytes
    for (int it = 0; it < 24; it++) begin
      logic [AW-1:0] a;
      int op;
      a  = {13'h0A51, 5'($urandom_range(0, 31))};
      op = $urandom_range(0, 3);
      case (op)
        0, 1: spi_write(a, 8'($urandom));
        2:    spi_read(a, "rand_spi_rd");
        default: tgt_read(a);
      endcase
    end

    check("no_oe_conflict", conflicts, 0);
    check("addr_data_stable", glitches, 0);

`ifdef SRAM_ARB_STATS_EN
    rst = 1'b1; tick(2); rst = 1'b0; tick(2);
    check("stat_after_rst", stat_defer, 0);
    for (int k = 0; k < 3; k++)
      concurrent_reads({13'h0A51, 5'($urandom_range(0, 31))}, 18'(k));
    check("stat_three_deferred", stat_defer, 3);
    spi_read(18'h00123, "stat_plain_rd");
    check("stat_plain_no_inc", stat_defer, 3);
    rst = 1'b1; tick(1);
    check("stat_rst_clear", stat_defer, 0);
    rst = 1'b0; tick(2);
`endif

    // Reset in the middle of a target read, with an SPI read pending behind it
    tgt_addr = 18'h00123; spi_addr = 18'h00007;
    tick(1);
    tgt_ce_n = 1'b0; tgt_oe_n = 1'b0; spi_oe_n = 1'b0;
    for (int i = 0; i < 20 && sram_oe_n; i++) @(negedge clk);
    check("rstmid_saw_read", !sram_oe_n, 1);
    tick(1);
    rst = 1'b1;
    tgt_ce_n = 1'b1; tgt_oe_n = 1'b1; spi_oe_n = 1'b1;
    tick(1);
    check("rstmid_oe_n", sram_oe_n, 1);
    check("rstmid_ce_n", sram_ce_n, 1);
    check("rstmid_dq_oe", sram_dq_oe, 0);
    tick(1);
    rst = 1'b0;
    tick(1);
    n0 = rd_log.size();
    tick(14);
    check("rstmid_pend_dropped", rd_log.size(), n0);
    check("rstmid_idle_ce_n", sram_ce_n, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
